// File: rtl/pll_supervisor.sv
// Supervisor for an iCE40 SB_PLL40_CORE: holds RESETB, waits for lock, qualifies it, retries, latches fault.
// Define PLL_LOSS_COUNTER_EN to build the saturating lock-loss counter; otherwise lock_lost_count is tied to 0.
module pll_supervisor #(
  parameter logic [3:0] DIVR          = 4'b0000,
  parameter logic [6:0] DIVF          = 7'b0101101,
  parameter logic [2:0] DIVQ          = 3'b001,
  parameter logic [2:0] FILTER_RANGE  = 3'b001,
  parameter int         HOLD_CYCLES   = 16,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         MAX_RETRIES   = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       clock_out,
  output logic       locked,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_lost_count
);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // One shared counter serves the hold, timeout and stability phases, so size it for the largest.
  localparam int MAX_HS  = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_HS > LOCK_TIMEOUT) ? MAX_HS : LOCK_TIMEOUT;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam int RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               locked_q, locked_d;
  logic               fault_q, fault_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               lock_meta_q, lock_sync_q;
  logic               pll_lock_raw;
  logic               pll_clk_core;

  SB_PLL40_CORE #(
    .FEEDBACK_PATH ("SIMPLE"),
    .DIVR          (DIVR),
    .DIVF          (DIVF),
    .DIVQ          (DIVQ),
    .FILTER_RANGE  (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK (clock_in),
    .RESETB       (pll_resetb_q),
    .BYPASS       (1'b0),
    .PLLOUTCORE   (pll_clk_core),
    .LOCK         (pll_lock_raw)
  );

  SB_GB u_gb_clk (
    .USER_SIGNAL_TO_GLOBAL_BUFFER (pll_clk_core),
    .GLOBAL_BUFFER_OUTPUT         (clock_out)
  );

  SB_GB u_gb_locked (
    .USER_SIGNAL_TO_GLOBAL_BUFFER (locked_q),
    .GLOBAL_BUFFER_OUTPUT         (locked)
  );

  // Raw LOCK comes from the analog PLL and is asynchronous to clock_in.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock_raw;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      retry_q      <= '0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
      pll_resetb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
      pll_resetb_q <= pll_resetb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_sync_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_HOLD;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_sync_q) begin
            cnt_d = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_sync_q) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          // Leaving FAULT starts a fresh set of attempts.
          if (clear_fault) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with the state itself.
  always_comb begin
    locked_d     = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAULT);
    pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
  end

  assign fault = fault_q;
  assign state = state_q;

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (enable && (state_q == ST_RUN) && !lock_sync_q && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_lost_count = loss_cnt_q;
`else
  assign lock_lost_count = 8'd0;
`endif

endmodule

`ifndef SYNTHESIS
// Behavioural stand-ins for the iCE40 primitives; the vendor cells replace these in synthesis.
module SB_PLL40_CORE #(
  parameter string      FEEDBACK_PATH = "SIMPLE",
  parameter logic [3:0] DIVR          = 4'b0000,
  parameter logic [6:0] DIVF          = 7'b0000000,
  parameter logic [2:0] DIVQ          = 3'b000,
  parameter logic [2:0] FILTER_RANGE  = 3'b000
) (
  input  logic REFERENCECLK,
  input  logic RESETB,
  input  logic BYPASS,
  output logic PLLOUTCORE,
  output logic LOCK
);
  localparam bit         SIMPLE_FB = (FEEDBACK_PATH == "SIMPLE");
  localparam logic [7:0] LOCK_DLY  = 8'd4 + 8'(DIVR) + 8'(DIVQ) + 8'(FILTER_RANGE) + 8'(DIVF[6:4]);

  logic [7:0] lock_cnt_q;

  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      lock_cnt_q <= 8'd0;
    end else if (lock_cnt_q != LOCK_DLY) begin
      lock_cnt_q <= lock_cnt_q + 8'd1;
    end
  end

  assign LOCK       = RESETB && (lock_cnt_q == LOCK_DLY);
  assign PLLOUTCORE = (SIMPLE_FB && !BYPASS) ? (REFERENCECLK & RESETB) : REFERENCECLK;
endmodule

module SB_GB (
  input  logic USER_SIGNAL_TO_GLOBAL_BUFFER,
  output logic GLOBAL_BUFFER_OUTPUT
);
  assign GLOBAL_BUFFER_OUTPUT = USER_SIGNAL_TO_GLOBAL_BUFFER;
endmodule
`endif

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small timing parameters; raw PLL lock is driven by forcing the lock net.
module tb_pll_supervisor;
  localparam int HOLD    = 4;
  localparam int STABLE  = 8;
  localparam int TIMEOUT = 32;
  localparam int RETRIES = 2;
`ifdef PLL_LOSS_COUNTER_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic       clk_out;
  logic       locked;
  logic       fault;
  logic [2:0] st;
  logic [7:0] llc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pll_supervisor #(
    .HOLD_CYCLES   (HOLD),
    .STABLE_CYCLES (STABLE),
    .LOCK_TIMEOUT  (TIMEOUT),
    .MAX_RETRIES   (RETRIES)
  ) dut (
    .clock_in        (clk),
    .reset_n         (rst_n),
    .enable          (en),
    .clear_fault     (clr),
    .clock_out       (clk_out),
    .locked          (locked),
    .fault           (fault),
    .state           (st),
    .lock_lost_count (llc)
  );

  task automatic set_lock(input bit v);
    if (v) force dut.pll_lock_raw = 1'b1;
    else   force dut.pll_lock_raw = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (st === s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    set_lock(1'b0);
    @(negedge clk);
    checks++;
    if (st !== 3'd0 || locked !== 1'b0 || fault !== 1'b0 || llc !== 8'd0 || dut.pll_resetb_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d locked=%b fault=%b count=%0d resetb=%b expected 0/0/0/0/0",
               st, locked, fault, llc, dut.pll_resetb_q);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (st !== 3'd0) begin
      errors++;
      $display("FAIL idle_disabled: state=%0d expected 0", st);
    end
  endtask

  task automatic test_startup;
    logic [2:0] exp_st;
    en = 1'b1;
    for (int i = 1; i <= HOLD; i++) begin
      @(negedge clk);
      checks++;
      if (st !== 3'd1 || dut.pll_resetb_q !== 1'b0) begin
        errors++;
        $display("FAIL startup_hold c%0d: state=%0d resetb=%b expected state=1 resetb=0", i, st, dut.pll_resetb_q);
      end
    end
    @(negedge clk);
    checks++;
    if (st !== 3'd2 || dut.pll_resetb_q !== 1'b1) begin
      errors++;
      $display("FAIL startup_wait: state=%0d resetb=%b expected state=2 resetb=1", st, dut.pll_resetb_q);
    end
    set_lock(1'b1);
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      exp_st = (i <= 3) ? 3'd2 : (i <= 11) ? 3'd3 : 3'd4;
      checks++;
      if (st !== exp_st || locked !== (i == 12)) begin
        errors++;
        $display("FAIL startup_lock c%0d: state=%0d locked=%b expected state=%0d locked=%b",
                 i, st, locked, exp_st, (i == 12));
      end
    end
  endtask

  task automatic test_glitch;
    int n;
    logic [2:0] exp_st;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 3'd0 || dut.pll_resetb_q !== 1'b0 || llc !== 8'd0) begin
      errors++;
      $display("FAIL disable_run: state=%0d resetb=%b count=%0d expected 0/0/0", st, dut.pll_resetb_q, llc);
    end
    en = 1'b1;
    wait_state(3'd3, 20, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL glitch_reach_stable: state=%0d expected 3 within 20 cycles", st);
    end
    @(negedge clk);
    @(negedge clk);
    set_lock(1'b0);
    @(negedge clk);
    set_lock(1'b1);
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk);
      exp_st = (c == 14) ? 3'd4 : 3'd3;
      checks++;
      if (st !== exp_st || locked !== (c == 14)) begin
        errors++;
        $display("FAIL glitch_restart c%0d: state=%0d locked=%b expected state=%0d locked=%b",
                 c, st, locked, exp_st, (c == 14));
      end
    end
  endtask

  task automatic test_enable_stable;
    int n;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    wait_state(3'd3, 20, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL en_reach_stable: state=%0d expected 3 within 20 cycles", st);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (st !== 3'd0 || dut.pll_resetb_q !== 1'b0) begin
      errors++;
      $display("FAIL disable_stable: state=%0d resetb=%b expected state=0 resetb=0", st, dut.pll_resetb_q);
    end
  endtask

  task automatic test_timeout_fault;
    int n;
    set_lock(1'b0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 109; i++) begin
      @(negedge clk);
      clr = 1'b0;
      case (i)
        4, 37, 73: begin
          checks++;
          if (st !== 3'd1 || dut.pll_resetb_q !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold c%0d: state=%0d resetb=%b expected state=1 resetb=0", i, st, dut.pll_resetb_q);
          end
        end
        5, 21, 36, 108: begin
          checks++;
          if (st !== 3'd2 || dut.pll_resetb_q !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait c%0d: state=%0d resetb=%b fault=%b expected state=2 resetb=1 fault=0",
                     i, st, dut.pll_resetb_q, fault);
          end
        end
        109: begin
          checks++;
          if (st !== 3'd5 || fault !== 1'b1 || dut.pll_resetb_q !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL fault_entry: state=%0d fault=%b resetb=%b locked=%b expected 5/1/0/0",
                     st, fault, dut.pll_resetb_q, locked);
          end
        end
        default: ;
      endcase
      // A clear_fault pulse outside FAULT must be ignored.
      if (i == 20) clr = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (st !== 3'd5) begin
      errors++;
      $display("FAIL fault_hold: state=%0d expected 5", st);
    end
    clr = 1'b1;
    set_lock(1'b1);
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (st !== 3'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: state=%0d fault=%b expected state=0 fault=0", st, fault);
    end
    wait_state(3'd4, 40, n);
    checks++;
    if (n < 0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL fault_recover: state=%0d locked=%b expected state=4 locked=1", st, locked);
    end
  endtask

  task automatic test_lock_loss;
    int n;
    logic [7:0] exp_c;
    set_lock(1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (st !== 3'd4 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_latency: state=%0d locked=%b expected state=4 locked=1", st, locked);
    end
    @(negedge clk);
    exp_c = LOSS_EN ? 8'd1 : 8'd0;
    checks++;
    if (st !== 3'd1 || locked !== 1'b0 || llc !== exp_c) begin
      errors++;
      $display("FAIL loss_first: state=%0d locked=%b count=%0d expected state=1 locked=0 count=%0d",
               st, locked, llc, exp_c);
    end
    for (int k = 1; k <= 300; k++) begin
      set_lock(1'b1);
      wait_state(3'd4, 40, n);
      checks++;
      if (n < 0) begin
        errors++;
        $display("FAIL loss_relock k%0d: state=%0d expected 4 within 40 cycles", k, st);
        break;
      end
      set_lock(1'b0);
      wait_state(3'd1, 10, n);
      checks++;
      if (n < 0) begin
        errors++;
        $display("FAIL loss_drop k%0d: state=%0d expected 1 within 10 cycles", k, st);
        break;
      end
      if (k == 1 || k == 254) begin
        exp_c = LOSS_EN ? 8'(k + 1) : 8'd0;
        checks++;
        if (llc !== exp_c) begin
          errors++;
          $display("FAIL loss_count k%0d: count=%0d expected %0d", k, llc, exp_c);
        end
      end
    end
    exp_c = LOSS_EN ? 8'd255 : 8'd0;
    checks++;
    if (llc !== exp_c) begin
      errors++;
      $display("FAIL loss_saturate: count=%0d expected %0d", llc, exp_c);
    end
  endtask

  task automatic test_async_reset;
    int n;
    set_lock(1'b1);
    wait_state(3'd4, 40, n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL areset_reach_run: state=%0d expected 4 within 40 cycles", st);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (st !== 3'd0 || dut.pll_resetb_q !== 1'b0 || locked !== 1'b0 || fault !== 1'b0 || llc !== 8'd0) begin
      errors++;
      $display("FAIL areset_async: state=%0d resetb=%b locked=%b fault=%b count=%0d expected all 0",
               st, dut.pll_resetb_q, locked, fault, llc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (st !== 3'd0) begin
      errors++;
      $display("FAIL areset_release: state=%0d expected 0 before first edge", st);
    end
    @(negedge clk);
    checks++;
    if (st !== 3'd1) begin
      errors++;
      $display("FAIL areset_restart: state=%0d expected 1", st);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_glitch();
    test_enable_stable();
    test_timeout_fault();
    test_lock_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
